// File: rtl/canyon_input_pkg.sv
// Shared scan codes and coin shaper state encoding for the Canyon Bomber input conditioner.
package canyon_input_pkg;
  localparam logic [8:0] KC_SPACE = 9'h029;
  localparam logic [8:0] KC_CTRL  = 9'h014;
  localparam logic [8:0] KC_F1    = 9'h005;
  localparam logic [8:0] KC_1     = 9'h016;
  localparam logic [8:0] KC_F2    = 9'h006;
  localparam logic [8:0] KC_2     = 9'h01E;
  localparam logic [8:0] KC_5     = 9'h02E;
  localparam logic [8:0] KC_6     = 9'h036;
  localparam logic [8:0] KC_A     = 9'h01C;

  typedef enum logic [1:0] {ARM, IDLE, PULSE} coin_state_t;
endpackage

// File: rtl/canyon_coin_pulse.sv
// Turns a raw coin request into one active-low pulse of exactly COIN_CYC cycles per press.
module canyon_coin_pulse
  import canyon_input_pkg::*;
#(
  parameter int unsigned COIN_CYC = 600000
) (
  input  logic clk_sys,
  input  logic Reset_I,
  input  logic raw,
  output logic coin_n
);
  localparam int unsigned CW = (COIN_CYC > 1) ? $clog2(COIN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_CYC - 1);

  coin_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          coin_n_q, coin_n_d;

  always_ff @(posedge clk_sys) begin
    if (!Reset_I) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      coin_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      coin_n_q <= coin_n_d;
    end
  end

  // ARM waits for a release so a coin held through reset or a pulse never re-triggers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_n_d = coin_n_q;
    unique case (state_q)
      ARM: begin
        coin_n_d = 1'b1;
        if (!raw) state_d = IDLE;
      end
      IDLE: begin
        coin_n_d = 1'b1;
        if (raw) begin
          state_d  = PULSE;
          cnt_d    = CNT_LOAD;
          coin_n_d = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          coin_n_d = 1'b1;
          state_d  = raw ? ARM : IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d  = ARM;
        coin_n_d = 1'b1;
      end
    endcase
  end

  assign coin_n = coin_n_q;
endmodule

// File: rtl/canyon_input_cond.sv
// PS/2 key decode merged with MiSTer joystick words; registered active-low Coin/Start/Fire.
module canyon_input_cond
  import canyon_input_pkg::*;
#(
  parameter int unsigned COIN_CYC = 600000
) (
  input  logic        clk_sys,
  input  logic        Reset_I,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic        Coin1_O,
  output logic        Coin2_O,
  output logic        Start1_O,
  output logic        Start2_O,
  output logic        Fire1_O,
  output logic        Fire2_O
);
  logic tgl_q, ev;
  logic k_fire_q, k_fire2_q, k_start1_q, k_start2_q, k_coin1_q, k_coin2_q;
  logic k_fire_d, k_fire2_d, k_start1_d, k_start2_d, k_coin1_d, k_coin2_d;
  logic fire1_n_q, fire2_n_q, start1_n_q, start2_n_q;
  logic fire1, fire2, start1, start2, coin1_raw, coin2_raw;
  logic unused_joy;

  assign unused_joy = &{1'b0, joystick_0[15:7], joystick_0[3:0],
                        joystick_1[15:7], joystick_1[3:0]};

  // Tracking the toggle even in reset keeps the first post-reset cycle event-free.
  assign ev = ps2_key[10] ^ tgl_q;

  always_comb begin
    k_fire_d   = k_fire_q;
    k_fire2_d  = k_fire2_q;
    k_start1_d = k_start1_q;
    k_start2_d = k_start2_q;
    k_coin1_d  = k_coin1_q;
    k_coin2_d  = k_coin2_q;
    if (ev) begin
      case (ps2_key[8:0])
        KC_SPACE, KC_CTRL: k_fire_d   = ps2_key[9];
        KC_F1, KC_1:       k_start1_d = ps2_key[9];
        KC_F2, KC_2:       k_start2_d = ps2_key[9];
        KC_5:              k_coin1_d  = ps2_key[9];
        KC_6:              k_coin2_d  = ps2_key[9];
        KC_A:              k_fire2_d  = ps2_key[9];
        default: ;
      endcase
    end
  end

  assign fire1     = k_fire_q   | joystick_0[4];
  assign fire2     = k_fire2_q  | joystick_1[4];
  assign start1    = k_start1_q | joystick_0[5];
  assign start2    = k_start2_q | joystick_1[5];
  assign coin1_raw = k_coin1_q  | joystick_0[6] | joystick_1[6];
  assign coin2_raw = k_coin2_q;

  always_ff @(posedge clk_sys) begin
    tgl_q <= ps2_key[10];
    if (!Reset_I) begin
      k_fire_q   <= 1'b0;
      k_fire2_q  <= 1'b0;
      k_start1_q <= 1'b0;
      k_start2_q <= 1'b0;
      k_coin1_q  <= 1'b0;
      k_coin2_q  <= 1'b0;
      fire1_n_q  <= 1'b1;
      fire2_n_q  <= 1'b1;
      start1_n_q <= 1'b1;
      start2_n_q <= 1'b1;
    end else begin
      k_fire_q   <= k_fire_d;
      k_fire2_q  <= k_fire2_d;
      k_start1_q <= k_start1_d;
      k_start2_q <= k_start2_d;
      k_coin1_q  <= k_coin1_d;
      k_coin2_q  <= k_coin2_d;
      fire1_n_q  <= ~fire1;
      fire2_n_q  <= ~fire2;
      start1_n_q <= ~start1;
      start2_n_q <= ~start2;
    end
  end

  canyon_coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin1 (
    .clk_sys (clk_sys),
    .Reset_I (Reset_I),
    .raw     (coin1_raw),
    .coin_n  (Coin1_O)
  );

  canyon_coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin2 (
    .clk_sys (clk_sys),
    .Reset_I (Reset_I),
    .raw     (coin2_raw),
    .coin_n  (Coin2_O)
  );

  assign Fire1_O  = fire1_n_q;
  assign Fire2_O  = fire2_n_q;
  assign Start1_O = start1_n_q;
  assign Start2_O = start2_n_q;
endmodule
